// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button conditioning, run/stop/lap FSM and centisecond tick for the stopwatch chain.
// Define STOPWATCH_CTRL_LAP_EN to enable the lap button and LAP state.
module stopwatch_ctrl #(
    parameter int DIV       = 500000,
    parameter int DB_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_reset,
    output logic       tick,
    output logic       clr,
    output logic       pause,
    output logic       hold,
    output logic [1:0] state
);
    localparam int PW = $clog2(DIV);
    localparam int CW = $clog2(DB_CYCLES + 1);
`ifdef STOPWATCH_CTRL_LAP_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2, LAP = 2'd3} state_t;

    logic [NB-1:0] btn_raw, sync1_q, sync2_q, db_q, db_d, db_prev_q, press;
    logic [CW-1:0] cnt_q [NB];
    logic [CW-1:0] cnt_d [NB];
    logic [PW-1:0] pre_q, pre_d;
    state_t        state_q, state_d;
    logic          clr_q, pause_q, hold_q, tick_q, running, running_nx, lap_p;

    // Button bit order: 0 = start, 1 = reset, 2 = lap (when present)
`ifdef STOPWATCH_CTRL_LAP_EN
    assign btn_raw = {btn_lap, btn_reset, btn_start};
    assign lap_p   = press[2];
`else
    logic unused_lap;
    assign btn_raw    = {btn_reset, btn_start};
    assign lap_p      = 1'b0;
    assign unused_lap = btn_lap;
`endif

    assign press = db_q & ~db_prev_q;

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CW'(DB_CYCLES - 1)) db_d[i] = sync2_q[i];
                else cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // One winning press per cycle; a winner that is ignored in the current state still masks the others
    always_comb begin
        state_d = state_q;
        if (press[1])
            state_d = (state_q == STOP) ? IDLE : state_q;
        else if (press[0])
            state_d = (state_q == RUN || state_q == LAP) ? STOP : RUN;
        else if (lap_p)
            state_d = (state_q == RUN) ? LAP : (state_q == LAP) ? RUN : state_q;
        running    = (state_q == RUN) || (state_q == LAP);
        running_nx = (state_d == RUN) || (state_d == LAP);
        // Prescaler freezes on the edges entering and leaving a running state, so STOP keeps the partial count
        pre_d = (state_d == IDLE) ? '0 :
                (running && running_nx) ? ((pre_q == PW'(DIV - 1)) ? '0 : pre_q + PW'(1)) : pre_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            cnt_q     <= '{default: '0};
            pre_q     <= '0;
            state_q   <= IDLE;
            clr_q     <= 1'b1;
            pause_q   <= 1'b1;
            hold_q    <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
            pre_q     <= pre_d;
            state_q   <= state_d;
            clr_q     <= state_d == IDLE;
            pause_q   <= (state_d == IDLE) || (state_d == STOP);
            hold_q    <= state_d == LAP;
            tick_q    <= running_nx && (pre_d == PW'(DIV - 1));
        end
    end

    assign tick  = tick_q;
    assign clr   = clr_q;
    assign pause = pause_q;
    assign hold  = hold_q;
    assign state = state_q;
endmodule
